// File: rtl/pushbutton_debounce.sv
// pushbutton_debounce: per-channel two-flop synchronizer plus 4-state debounce FSM.
// Optional PUSHBUTTON_DEBOUNCE_PULSE_EN adds a one-clock press_pulse per accepted press.
module pushbutton_debounce #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_btn,
   output logic [WIDTH-1:0] db_out,
`ifdef PUSHBUTTON_DEBOUNCE_PULSE_EN
   output logic [WIDTH-1:0] press_pulse,
`endif
   output logic             any_pressed
);
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   localparam logic [WIDTH-1:0] REL  = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] s1_q, s2_q, p;
   // Sync flops reset to the released level so a held button still debounces after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= REL;
         s2_q <= REL;
      end else begin
         s1_q <= raw_btn;
         s2_q <= s1_q;
      end
   end
   assign p = s2_q ^ REL;
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             db_q, db_d;
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            RELEASED:
               if (p[i]) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = '0;
               end
            PRESS_WAIT:
               if (!p[i]) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == LAST) state_d = PRESSED;
               else cnt_d = cnt_q + 1'b1;
            PRESSED:
               if (!p[i]) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = '0;
               end
            RELEASE_WAIT:
               if (p[i]) state_d = PRESSED;
               else if (cnt_q == LAST) state_d = RELEASED;
               else cnt_d = cnt_q + 1'b1;
         endcase
         db_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      end
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            db_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
         end
      end
      assign db_out[i] = db_q;
`ifdef PUSHBUTTON_DEBOUNCE_PULSE_EN
      logic pulse_q, pulse_d;
      // Only a fresh acceptance pulses; a rejected release bounce does not.
      assign pulse_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) pulse_q <= 1'b0;
         else pulse_q <= pulse_d;
      end
      assign press_pulse[i] = pulse_q;
`endif
   end
   assign any_pressed = |db_out;
endmodule

// File: tb/tb_pushbutton_debounce.sv
// tb_pushbutton_debounce: directed plus random stimulus against a run-length debounce model.
module tb_pushbutton_debounce;
   localparam int W = 2;
   localparam int D = 4;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] raw_btn = '1;
   logic [W-1:0] db_out;
   logic         any_pressed;
   logic [W-1:0] pulse;
   int           errors = 0;
   int           checks = 0;
`ifdef PUSHBUTTON_DEBOUNCE_PULSE_EN
   logic [W-1:0] press_pulse;
   assign pulse = press_pulse;
`else
   assign pulse = '0;
`endif
   pushbutton_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(1)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .raw_btn(raw_btn),
      .db_out(db_out),
`ifdef PUSHBUTTON_DEBOUNCE_PULSE_EN
      .press_pulse(press_pulse),
`endif
      .any_pressed(any_pressed)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   // Model: a level is accepted once the synchronized pressed level has differed
   // from the accepted level on D+1 consecutive clock edges.
   logic [W-1:0] m_s1, m_s2, m_db, m_pulse;
   int           run [W];
   always @(posedge clk or negedge reset_n) begin : model
      logic pl;
      if (!reset_n) begin
         m_s1 = '1;
         m_s2 = '1;
         m_db = '0;
         m_pulse = '0;
         for (int c = 0; c < W; c++) run[c] = 0;
      end else begin
         for (int c = 0; c < W; c++) begin
            pl = ~m_s2[c];
            m_pulse[c] = 1'b0;
            if (pl != m_db[c]) begin
               run[c]++;
               if (run[c] == D + 1) begin
                  m_db[c] = pl;
                  m_pulse[c] = pl;
                  run[c] = 0;
               end
            end else run[c] = 0;
         end
         m_s2 = m_s1;
         m_s1 = raw_btn;
      end
   end
   always @(negedge clk) begin
      check("db_out", 32'(db_out), 32'(m_db));
      check("any_pressed", 32'(any_pressed), 32'(|m_db));
`ifdef PUSHBUTTON_DEBOUNCE_PULSE_EN
      check("press_pulse", 32'(pulse), 32'(m_pulse));
`endif
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      int pulses;
      tick(3);
      check("reset_db", 32'(db_out), 32'h0);
      check("reset_any", 32'(any_pressed), 32'h0);
      #2 reset_n = 1'b1;
      tick(3);
      // clean press on channel 0: accepted D+2 edges after the first sampling edge
      raw_btn = 2'b10;
      tick(6);
      check("press_early", 32'(db_out), 32'h0);
      tick(1);
      check("press_db", 32'(db_out), 32'h1);
      check("press_any", 32'(any_pressed), 32'h1);
      // release bounce rejected, then stable release
      raw_btn = 2'b11;
      tick(2);
      raw_btn = 2'b10;
      tick(8);
      check("rel_bounce_held", 32'(db_out), 32'h1);
      raw_btn = 2'b11;
      tick(6);
      check("release_early", 32'(db_out), 32'h1);
      tick(1);
      check("release_db", 32'(db_out), 32'h0);
      check("release_any", 32'(any_pressed), 32'h0);
      // press bounce of 3 clocks rejected
      raw_btn = 2'b10;
      tick(3);
      raw_btn = 2'b11;
      tick(10);
      check("press_bounce", 32'(db_out), 32'h0);
      // reset mid-count discards progress; held button then debounces from scratch
      raw_btn = 2'b10;
      tick(4);
      #2 reset_n = 1'b0;
      tick(2);
      #2 reset_n = 1'b1;
      tick(6);
      check("post_reset_early", 32'(db_out), 32'h0);
      tick(1);
      check("post_reset_db", 32'(db_out), 32'h1);
      tick(1);
      #2 reset_n = 1'b0;
      #1 check("reset_immediate", 32'(db_out), 32'h0);
      tick(1);
      raw_btn = 2'b11;
      #2 reset_n = 1'b1;
      tick(8);
      // parallel press on both channels
      raw_btn = 2'b00;
      tick(6);
      check("par_early", 32'(db_out), 32'h0);
      tick(1);
      check("par_db", 32'(db_out), 32'h3);
      raw_btn = 2'b11;
      tick(10);
      check("par_release", 32'(db_out), 32'h0);
      // press / release / press: one pulse per accepted press
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (i % 10 == 0) raw_btn[0] = (i % 20 != 0);
         @(negedge clk);
         if (pulse[0]) pulses++;
      end
`ifdef PUSHBUTTON_DEBOUNCE_PULSE_EN
      check("pulse_count", 32'(pulses), 32'd2);
`endif
      raw_btn = 2'b11;
      tick(10);
      // randomized runs of various lengths, with occasional resets
      for (int i = 0; i < 1500; i++) begin
         raw_btn = W'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            #2 reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
         tick($urandom_range(1, 8));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
